regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite / rd / Write_data) between two writeback requesters: port A (ALU/CSR results) and port B (load unit).
- Round-robin arbitration with valid/ready handshakes and a registered write stage.
- Keeps a per-register busy scoreboard so issue logic can detect RAW hazards against writes not yet committed.
- Sits between the execute/memory stages and Register_File.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width.
- NREG, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  port A has a write pending.
- a_rd  in  ADDR_W  port A destination register.
- a_data  in  DATA_W  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- b_valid  in  1  port B has a write pending.
- b_rd  in  ADDR_W  port B destination register.
- b_data  in  DATA_W  port B write data.
- b_ready  out  1  port B request accepted this cycle.
- wb_hold  in  1  freeze acceptance; both readies low.
- iss_valid  in  1  an instruction with a destination is issuing.
- iss_rd  in  ADDR_W  destination of the issuing instruction.
- iss_rs1  in  ADDR_W  source 1 of the instruction being checked.
- iss_rs2  in  ADDR_W  source 2 of the instruction being checked.
- hazard  out  1  busy[iss_rs1] | busy[iss_rs2]; combinational.
- busy  out  NREG  scoreboard vector; bit 0 is always 0.
- RegWrite  out  1  write strobe to the register file; registered.
- wr_rd  out  ADDR_W  write index; registered.
- Write_data  out  DATA_W  write data; registered.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - RegWrite=0, wr_rd=0, Write_data=0, busy=0.
  - Priority pointer prio=A.
  - Reset overrides all same-cycle requests and issues.
- Acceptance (combinational):
  - a_ready = !reset & !wb_hold & a_valid & (!b_valid | prio==A).
  - b_ready = !reset & !wb_hold & b_valid & (!a_valid | prio==B).
  - At most one ready is high per cycle.
  - Ready never goes high without the matching valid.
- Handshake:
  - A transfer occurs when valid & ready.
  - A requester holds valid, rd and data stable until ready is seen.
  - Dropping valid before acceptance is legal; nothing is recorded.
- Pointer update:
  - Only when both valid and one side is accepted: prio flips to the other port.
  - A single uncontested accept leaves prio unchanged.
- Write stage (1-cycle latency, one clk edge after acceptance):
  - RegWrite=1, wr_rd=accepted rd, Write_data=accepted data.
  - If accepted rd==0: RegWrite=0; the transfer is consumed and the x0 write is dropped.
  - With no acceptance: RegWrite=0. wr_rd and Write_data hold their last values.
- Scoreboard (per clk edge, not during reset):
  - Clear: on acceptance of rd≠0, busy[rd] is cleared at the same edge that raises RegWrite.
  - Set: iss_valid with iss_rd≠0 sets busy[iss_rd].
  - Same register set and cleared in the same cycle: set wins (a newer producer exists).
  - Issuing to an already-busy register leaves it busy (no count). Issue logic must not issue a second producer of the same rd while busy[rd]=1.
  - busy[0] is constant 0.
- hazard is purely combinational from the current busy vector and iss_rs1/iss_rs2. It does not see writes accepted in the same cycle.
- wb_hold=1:
  - No acceptance, prio unchanged.
  - The write stage drains normally: a write accepted the previous cycle still commits.
- Arbitration fairness: with both ports continuously valid, grants alternate A,B,A,B…; no starvation beyond one cycle.

Test Plan:
- Reset: assert reset 2 cycles with a_valid=b_valid=1 and iss_valid=1, iss_rd=5 -> readies low, RegWrite=0, busy=0, prio=A after deassert.
- Single write: a_valid, a_rd=3, a_data=0xDEADBEEF -> a_ready=1 that cycle; next cycle RegWrite=1, wr_rd=3, Write_data=0xDEADBEEF; then RegWrite=0.
- Contention: both valid for 4 cycles (A rd=1, B rd=2) -> grant order A,B,A,B; RegWrite high 4 consecutive cycles with wr_rd 1,2,1,2.
- Scoreboard: issue rd=7, then check iss_rs1=7 -> hazard=1. B writes rd=7 -> busy[7] clears with RegWrite, hazard=0 the following cycle. Issue rd=7 in the same cycle as the B accept -> busy[7] stays 1.
- x0: a_rd=0, a_data=0x1234 and iss_rd=0 -> a_ready=1, RegWrite stays 0, busy stays 0.
- Hold: accept A (rd=4), then wb_hold=1 for 3 cycles with B valid -> A's write commits the next cycle, b_ready=0 for 3 cycles, B is accepted on the first cycle after hold drops.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result producers, the issue checker and the
// register-file write port. Requesters assert valid; the arbiter raises ready
// in the same cycle it accepts, so a transfer is valid & ready on a clock edge,
// and a requester holds valid/rd/data stable until it sees ready.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              wb_hold;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W-1:0] iss_rs1;
  logic [ADDR_W-1:0] iss_rs2;
  logic              hazard;
  logic [NREG-1:0]   busy;
  logic              RegWrite;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] Write_data;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, wb_hold,
           iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  a_ready, b_ready, hazard, busy, RegWrite, wr_rd, Write_data
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, wb_hold,
           iss_valid, iss_rd, iss_rs1, iss_rs2,
    output a_ready, b_ready, hazard, busy, RegWrite, wr_rd, Write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between port A
// (ALU/CSR) and port B (loads), with a registered write stage and busy scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic               clk,
  input  logic               reset,
  regfile_wb_arbiter_if.slave bus,
  output logic               o_prio_dbg
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e             r_prio;
  prio_e             w_prio_nxt;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_acc;
  logic              w_acc_live;
  logic [ADDR_W-1:0] w_acc_rd;
  logic [DATA_W-1:0] w_acc_data;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_wr_rd;
  logic [DATA_W-1:0] r_write_data;

  always_comb begin
    w_a_ready  = !reset && !bus.wb_hold && bus.a_valid && (!bus.b_valid || r_prio == PRIO_A);
    w_b_ready  = !reset && !bus.wb_hold && bus.b_valid && (!bus.a_valid || r_prio == PRIO_B);
    w_acc      = w_a_ready || w_b_ready;
    w_acc_rd   = w_a_ready ? bus.a_rd : bus.b_rd;
    w_acc_data = w_a_ready ? bus.a_data : bus.b_data;
    // An accepted x0 write is consumed but never reaches the register file.
    w_acc_live = w_acc && (w_acc_rd != '0);

    w_prio_nxt = r_prio;
    if (bus.a_valid && bus.b_valid && w_acc)
      w_prio_nxt = (r_prio == PRIO_A) ? PRIO_B : PRIO_A;

    // Set after clear: a new producer issued this cycle keeps the register busy.
    w_busy_nxt = r_busy;
    if (w_acc_live)
      w_busy_nxt[w_acc_rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != '0)
      w_busy_nxt[bus.iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= PRIO_A;
      r_busy <= '0;
    end else begin
      r_prio <= w_prio_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite   <= 1'b0;
      r_wr_rd      <= '0;
      r_write_data <= '0;
    end else begin
      r_regwrite <= w_acc_live;
      if (w_acc_live) begin
        r_wr_rd      <= w_acc_rd;
        r_write_data <= w_acc_data;
      end
    end
  end

  assign bus.a_ready    = w_a_ready;
  assign bus.b_ready    = w_b_ready;
  assign bus.hazard     = r_busy[bus.iss_rs1] | r_busy[bus.iss_rs2];
  assign bus.busy       = r_busy;
  assign bus.RegWrite   = r_regwrite;
  assign bus.wr_rd      = r_wr_rd;
  assign bus.Write_data = r_write_data;
  assign o_prio_dbg     = (r_prio == PRIO_B);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// reference model, with a queue-based scoreboard checking every committed write.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int W      = ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic prio_dbg;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) bus();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_prio_dbg (prio_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  // reference model: set of registers with an outstanding producer, and which
  // port gets the next contested grant (0 = A, 1 = B)
  logic [NREG-1:0] m_busy = '0;
  int              m_next_contest = 0;
  bit              a_took = 1'b0;
  bit              b_took = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: acceptance, pointer, scoreboard ----------------
  initial forever begin
    logic ea, eb;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    if (reset) begin
      chk("rst_a_ready", bus.a_ready, 0);
      chk("rst_b_ready", bus.b_ready, 0);
      m_busy = '0;
      m_next_contest = 0;
      a_took = 1'b0;
      b_took = 1'b0;
    end else begin
      chk("busy", bus.busy, m_busy);
      chk("hazard", bus.hazard, m_busy[bus.iss_rs1] | m_busy[bus.iss_rs2]);
      if (bus.wb_hold) begin
        ea = 1'b0;
        eb = 1'b0;
      end else if (bus.a_valid && bus.b_valid) begin
        ea = (m_next_contest == 0);
        eb = (m_next_contest == 1);
      end else begin
        ea = bus.a_valid;
        eb = bus.b_valid;
      end
      chk("a_ready", bus.a_ready, ea);
      chk("b_ready", bus.b_ready, eb);
      a_took = ea;
      b_took = eb;
      if (ea || eb) begin
        rd = ea ? bus.a_rd : bus.b_rd;
        d  = ea ? bus.a_data : bus.b_data;
        if (rd != 0) begin
          exp_q.push_back({rd, d});
          exp_cyc_q.push_back(cyc + 1);
          m_busy[rd] = 1'b0;
        end
        // loser of a contest is served next time both ask
        if (bus.a_valid && bus.b_valid)
          m_next_contest = ea ? 1 : 0;
      end
      if (bus.iss_valid && bus.iss_rd != 0)
        m_busy[bus.iss_rd] = 1'b1;
    end
  end

  // ---------------- monitor: pops expected writes ----------------
  initial forever begin
    logic [W-1:0] e;
    int c;
    @(negedge clk);
    if (bus.RegWrite) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", bus.RegWrite, 0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("wr_entry", {bus.wr_rd, bus.Write_data}, e);
        chk("wr_latency", cyc, c);
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      chk("missed_write", bus.RegWrite, 1);
      e = exp_q.pop_front();
      c = exp_cyc_q.pop_front();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.wb_hold   = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic drive_a(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    bus.a_valid = 1'b1;
    bus.a_rd    = rd;
    bus.a_data  = d;
  endtask

  task automatic drive_b(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    bus.b_valid = 1'b1;
    bus.b_rd    = rd;
    bus.b_data  = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.a_valid = 1'b1; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b1; bus.b_rd = '0; bus.b_data = '0;
    bus.wb_hold = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    bus.iss_rs1 = '0; bus.iss_rs2 = '0;

    // reset held two cycles with requests and an issue pending
    tick();
    tick();
    reset = 1'b0;
    idle();
    chk("rst_prio", prio_dbg, 0);
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_wr_rd", bus.wr_rd, 0);
    chk("rst_write_data", bus.Write_data, 0);
    chk("rst_busy", bus.busy, 0);

    // single uncontested write
    tick();
    drive_a(5'd3, 32'hDEADBEEF);
    settle();
    chk("single_a_ready", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;
    settle();
    chk("single_regwrite", bus.RegWrite, 1);
    chk("single_wr_rd", bus.wr_rd, 3);
    chk("single_data", bus.Write_data, 32'hDEADBEEF);
    tick();
    chk("single_regwrite_off", bus.RegWrite, 0);

    // contention: alternating grants A,B,A,B
    drive_a(5'd1, 32'h1111_0001);
    drive_b(5'd2, 32'h2222_0002);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("cont_a_ready", bus.a_ready, (k % 2) == 0);
      chk("cont_b_ready", bus.b_ready, (k % 2) == 1);
      if (k > 0) begin
        chk("cont_regwrite", bus.RegWrite, 1);
        chk("cont_wr_rd", bus.wr_rd, (k % 2) == 1 ? 1 : 2);
      end
      tick();
    end
    idle();
    settle();
    chk("cont_last_regwrite", bus.RegWrite, 1);
    chk("cont_last_wr_rd", bus.wr_rd, 2);
    tick();

    // scoreboard: set, hazard, clear with write, same-cycle set wins
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    bus.iss_valid = 1'b0; bus.iss_rs1 = 5'd7; bus.iss_rs2 = 5'd0;
    settle();
    chk("sb_hazard_set", bus.hazard, 1);
    chk("sb_busy7_set", bus.busy[7], 1);
    drive_b(5'd7, 32'h0000_0077);
    settle();
    chk("sb_b_ready", bus.b_ready, 1);
    chk("sb_hazard_same_cycle", bus.hazard, 1);
    tick();
    bus.b_valid = 1'b0;
    settle();
    chk("sb_clear_regwrite", bus.RegWrite, 1);
    chk("sb_busy7_clear", bus.busy[7], 0);
    chk("sb_hazard_clear", bus.hazard, 0);
    drive_b(5'd7, 32'h0000_0078);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    idle();
    settle();
    chk("sb_set_wins", bus.busy[7], 1);
    chk("sb_set_wins_hazard", bus.hazard, 1);
    drive_a(5'd7, 32'h0000_0079);
    tick();
    idle();
    tick();

    // x0 write and x0 issue
    drive_a(5'd0, 32'h0000_1234);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    settle();
    chk("x0_a_ready", bus.a_ready, 1);
    tick();
    idle();
    settle();
    chk("x0_regwrite", bus.RegWrite, 0);
    chk("x0_busy", bus.busy, 0);
    tick();

    // hold: accepted write drains, B waits out the hold
    drive_a(5'd4, 32'h0000_0044);
    tick();
    bus.a_valid = 1'b0;
    drive_b(5'd9, 32'h0000_0099);
    bus.wb_hold = 1'b1;
    settle();
    chk("hold_drain_regwrite", bus.RegWrite, 1);
    chk("hold_drain_wr_rd", bus.wr_rd, 4);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("hold_b_ready", bus.b_ready, 0);
      tick();
    end
    bus.wb_hold = 1'b0;
    settle();
    chk("hold_release_b_ready", bus.b_ready, 1);
    tick();
    idle();
    settle();
    chk("hold_b_commit", bus.wr_rd, 9);
    tick();

    // randomized traffic respecting the handshake and the issue rule
    for (int i = 0; i < 3000; i++) begin
      logic [ADDR_W-1:0] r;
      if (!bus.a_valid || a_took) begin
        bus.a_valid = $urandom_range(0, 99) < 55;
        bus.a_rd    = ADDR_W'($urandom_range(0, NREG - 1));
        bus.a_data  = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        bus.a_valid = 1'b0;
      end
      if (!bus.b_valid || b_took) begin
        bus.b_valid = $urandom_range(0, 99) < 55;
        bus.b_rd    = ADDR_W'($urandom_range(0, NREG - 1));
        bus.b_data  = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        bus.b_valid = 1'b0;
      end
      bus.wb_hold   = $urandom_range(0, 99) < 15;
      r             = ADDR_W'($urandom_range(0, NREG - 1));
      bus.iss_valid = ($urandom_range(0, 99) < 40) && !m_busy[r];
      bus.iss_rd    = r;
      bus.iss_rs1   = ADDR_W'($urandom_range(0, NREG - 1));
      bus.iss_rs2   = ADDR_W'($urandom_range(0, NREG - 1));
      tick();
    end

    idle();
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
